// File: rtl/alu16_seq_responder_if.sv
// Request/response bus between an ALU op issuer (master) and alu16_seq_responder (slave).
interface alu16_seq_responder_if #(
    parameter int WIDTH = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     Inp1;
    logic [WIDTH-1:0]     Inp2;
    logic [2:0]           Op_code;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*WIDTH-1:0]   Result;
    logic                 div_by_zero;
    logic                 busy;

    modport master (
        output req_valid, Inp1, Inp2, Op_code, rsp_ready,
        input  req_ready, rsp_valid, Result, div_by_zero, busy
    );

    modport slave (
        input  req_valid, Inp1, Inp2, Op_code, rsp_ready,
        output req_ready, rsp_valid, Result, div_by_zero, busy
    );
endinterface

// File: rtl/alu16_seq_responder.sv
// Handshaked 16-bit ALU: single-cycle add/sub/logic, 16-iteration shift-add multiply
// and restoring divide on operand magnitudes, with sign fixed up at the end.
module alu16_seq_responder #(
    parameter int WIDTH = 16,
    parameter int ITER  = WIDTH
) (
    input logic                   clk,
    input logic                   rst_n,
    alu16_seq_responder_if.slave  bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(ITER);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_NA  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [2:0]        op_q,     op_d;
    logic              neg_q,    neg_d;
    logic              dvz_q,    dvz_d;
    logic [RW-1:0]     acc_q,    acc_d;
    logic [RW-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]  shr_q,    shr_d;
    logic [WIDTH-1:0]  dvsr_q,   dvsr_d;
    logic [WIDTH-1:0]  rem_q,    rem_d;
    logic [RW-1:0]     result_q, result_d;
    logic              dbz_q,    dbz_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        mag = v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [RW-1:0] sext(input logic [WIDTH-1:0] v);
        sext = {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // shr_q holds the remaining multiplier bits (mul) or dividend-turning-quotient (div)
    logic [RW-1:0]     acc_step;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH:0]    rem_sub;
    logic              rem_ge;
    logic [WIDTH-1:0]  quo_step;
    logic [RW-1:0]     quo_ext;
    logic [RW-1:0]     fast_result;

    always_comb begin
        acc_step = shr_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_sh   = {rem_q, shr_q[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, dvsr_q});
        rem_sub  = rem_sh - {1'b0, dvsr_q};
        quo_step = {shr_q[WIDTH-2:0], rem_ge};
        quo_ext  = {{WIDTH{1'b0}}, quo_step};
    end

    always_comb begin
        fast_result = '0;
        case (bus.Op_code)
            OP_ADD:  fast_result = sext(bus.Inp1) + sext(bus.Inp2);
            OP_SUB:  fast_result = sext(bus.Inp1) - sext(bus.Inp2);
            OP_OR:   fast_result = {{WIDTH{1'b0}}, bus.Inp1 | bus.Inp2};
            OP_AND:  fast_result = {{WIDTH{1'b0}}, bus.Inp1 & bus.Inp2};
            OP_NA:   fast_result = {{WIDTH{1'b0}}, ~bus.Inp1};
            default: fast_result = {{WIDTH{1'b0}}, ~bus.Inp2};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        dvz_d    = dvz_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        shr_d    = shr_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d  = bus.Op_code;
                    dbz_d = 1'b0;
                    cnt_d = '0;
                    neg_d = bus.Inp1[WIDTH-1] ^ bus.Inp2[WIDTH-1];
                    dvz_d = (bus.Inp2 == '0);
                    if (bus.Op_code == OP_MUL) begin
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, mag(bus.Inp1)};
                        shr_d   = mag(bus.Inp2);
                        state_d = S_CALC;
                    end else if (bus.Op_code == OP_DIV) begin
                        rem_d   = '0;
                        shr_d   = mag(bus.Inp1);
                        dvsr_d  = mag(bus.Inp2);
                        state_d = S_CALC;
                    end else begin
                        result_d = fast_result;
                        state_d  = S_DONE;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d   = acc_step;
                    mcand_d = mcand_q << 1;
                    shr_d   = shr_q >> 1;
                end else begin
                    rem_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    shr_d = quo_step;
                end
                // The last iteration's value is folded straight into Result
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_DONE;
                    if (op_q == OP_MUL) begin
                        result_d = neg_q ? -acc_step : acc_step;
                    end else if (dvz_q) begin
                        result_d = '0;
                        dbz_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -quo_ext : quo_ext;
                    end
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            dvz_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            shr_q    <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            dvz_q    <= dvz_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            shr_q    <= shr_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.rsp_valid   = (state_q == S_DONE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.Result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu16_seq_responder.sv
// Directed plus random checks of alu16_seq_responder against an arithmetic reference model.
module tb_alu16_seq_responder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu16_seq_responder_if #(.WIDTH(16)) bus_if ();

    alu16_seq_responder #(.WIDTH(16), .ITER(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic on the operand values
    task automatic ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] r, output logic z);
        longint sa, sb, res;
        sa  = $signed(a);
        sb  = $signed(b);
        z   = 1'b0;
        res = 0;
        case (op)
            3'd0: res = sa + sb;
            3'd1: res = sa - sb;
            3'd2: res = sa * sb;
            3'd3: if (sb == 0) z = 1'b1; else res = sa / sb;
            3'd4: res = longint'(a | b);
            3'd5: res = longint'(a & b);
            3'd6: res = longint'(16'(~a));
            default: res = longint'(16'(~b));
        endcase
        r = res[31:0];
    endtask

    task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold);
        logic [31:0] exp_r, held;
        logic        exp_z;
        int          lat, exp_lat;
        ref_alu(op, a, b, exp_r, exp_z);
        exp_lat = (op == 3'd2 || op == 3'd3) ? 17 : 1;
        @(negedge clk);
        check("req_ready_idle", 64'(bus_if.req_ready), 64'd1);
        bus_if.req_valid = 1'b1;
        bus_if.Inp1      = a;
        bus_if.Inp2      = b;
        bus_if.Op_code   = op;
        bus_if.rsp_ready = (hold == 0);
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        bus_if.Inp1      = 16'($urandom);
        bus_if.Inp2      = 16'($urandom);
        bus_if.Op_code   = 3'($urandom);
        lat = 1;
        while (!bus_if.rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", 64'(bus_if.Result), 64'(exp_r));
        check("div_by_zero", 64'(bus_if.div_by_zero), 64'(exp_z));
        check("busy_done", 64'(bus_if.busy), 64'd1);
        check("req_ready_done", 64'(bus_if.req_ready), 64'd0);
        held = bus_if.Result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_result", 64'(bus_if.Result), 64'(held));
            check("bp_req_ready", 64'(bus_if.req_ready), 64'd0);
            check("bp_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
        end
        if (hold > 0) begin
            @(negedge clk);
            bus_if.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("rsp_valid_drop", 64'(bus_if.rsp_valid), 64'd0);
        check("req_ready_back", 64'(bus_if.req_ready), 64'd1);
        $display("txn op=%0d a=%04h b=%04h result=%08h dbz=%0d lat=%0d",
                 op, a, b, exp_r, exp_z, lat);
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.Inp1      = '0;
        bus_if.Inp2      = '0;
        bus_if.Op_code   = '0;
        bus_if.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 64'(bus_if.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        check("rst_result", 64'(bus_if.Result), 64'd0);
        check("rst_dbz", 64'(bus_if.div_by_zero), 64'd0);
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        do_op(3'd0, 16'd5, 16'd3, 0);
        do_op(3'd0, 16'd200, 16'hF3F5, 0);
        do_op(3'd2, 16'd321, 16'd56, 0);
        do_op(3'd2, 16'd200, 16'hF3F5, 0);
        do_op(3'd2, 16'h8000, 16'h8000, 0);
        do_op(3'd3, 16'hFF0F, 16'd80, 0);
        do_op(3'd3, 16'd7, 16'd0, 0);
        do_op(3'd3, 16'h8000, 16'hFFFF, 0);
        do_op(3'd1, 16'h8000, 16'h7FFF, 0);
        do_op(3'd4, 16'h000F, 16'h0C0A, 0);
        do_op(3'd5, 16'h0029, 16'h0C0A, 0);
        do_op(3'd6, 16'h0C7A, 16'h1234, 0);
        do_op(3'd7, 16'h1234, 16'h0C7A, 0);
        do_op(3'd3, 16'd100, 16'd7, 10);
        do_op(3'd0, 16'h7FFF, 16'h7FFF, 10);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            do_op(3'($urandom_range(0, 7)), ra, rb, int'($urandom_range(0, 2)));
        end

        // Abandon a multiply mid-iteration with an asynchronous reset
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.Inp1      = 16'd1234;
        bus_if.Inp2      = 16'd99;
        bus_if.Op_code   = 3'd2;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        check("mid_busy", 64'(bus_if.busy), 64'd1);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_req_ready", 64'(bus_if.req_ready), 64'd1);
        check("async_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        check("async_result", 64'(bus_if.Result), 64'd0);
        check("async_dbz", 64'(bus_if.div_by_zero), 64'd0);
        check("async_busy", 64'(bus_if.busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("no_stale_rsp", 64'(bus_if.rsp_valid), 64'd0);
        end
        do_op(3'd0, 16'hFFFF, 16'd2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
